// File: rtl/sr_drv_pkg.sv
// Shared types for the NAND SR latch driver: FSM states, err bit positions, timer width.
// Also provides the helper that turns a cycle count into a down-counter load value.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } sr_state_e;

  localparam int ERR_CONFLICT = 0;
  localparam int ERR_READBACK = 1;
  localparam int TIMER_W      = 4;

  // The phase ends in the cycle the counter reads zero, so an N-cycle phase loads N-1.
  function automatic logic [TIMER_W-1:0] cycles_to_load(input int unsigned n);
    if (n == 0) begin
      return '0;
    end
    return TIMER_W'(n - 1);
  endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// 4-bit down-counter with synchronous load and zero flag; zero_o is a decode of the register.
// Load wins over decrement; decrement saturates at zero.
module sr_pulse_timer
  import sr_drv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Drives a NAND SR latch with timed S_n/R_n pulses; done arrives PULSE_CYCLES+SETTLE_CYCLES+1 after accept.
// Requests are taken only while req_ready (IDLE); SR_READBACK_EN adds a Q/Q_not readback check in CHECK.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       req_ready,
  output logic       S_n,
  output logic       R_n,
  input  logic       Q_fb,
  input  logic       Q_not_fb,
  output logic       done,
  output logic [1:0] err,
  output logic       q_state
);

  localparam logic [TIMER_W-1:0] PULSE_LOAD  = cycles_to_load(PULSE_CYCLES);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = cycles_to_load(SETTLE_CYCLES);

  sr_state_e   state_q;
  logic        target_q;
  logic        s_n_q;
  logic        r_n_q;
  logic        done_q;
  logic [1:0]  err_q;
  logic        q_state_q;

  logic        idle;
  logic        accept_set;
  logic        accept_clr;
  logic        conflict;
  logic        readback_bad;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_val;
  logic               timer_dec;
  logic               timer_zero;

  assign idle       = (state_q == IDLE);
  assign accept_set = idle && set_req && !clr_req;
  assign accept_clr = idle && clr_req && !set_req;
  assign conflict   = idle && set_req && clr_req;

`ifdef SR_READBACK_EN
  assign readback_bad = (Q_fb != target_q) || (Q_not_fb != ~target_q);
`else
  logic unused_readback;
  assign unused_readback = Q_fb ^ Q_not_fb;
  assign readback_bad    = 1'b0;
`endif

  // One timer serves both timed phases: loaded on accept for PULSE, reloaded on PULSE exit for SETTLE.
  always_comb begin
    timer_load     = 1'b0;
    timer_load_val = '0;
    timer_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_set || accept_clr) begin
          timer_load     = 1'b1;
          timer_load_val = PULSE_LOAD;
        end
      end
      PULSE: begin
        if (timer_zero) begin
          timer_load     = 1'b1;
          timer_load_val = SETTLE_LOAD;
        end else begin
          timer_dec = 1'b1;
        end
      end
      SETTLE: timer_dec = 1'b1;
      default: ;
    endcase
  end

  sr_pulse_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= 1'b0;
      s_n_q     <= 1'b1;
      r_n_q     <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 2'b00;
      q_state_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (conflict) begin
            err_q[ERR_CONFLICT] <= 1'b1;
          end else if (accept_set) begin
            target_q <= 1'b1;
            s_n_q    <= 1'b0;
            state_q  <= PULSE;
          end else if (accept_clr) begin
            target_q <= 1'b0;
            r_n_q    <= 1'b0;
            state_q  <= PULSE;
          end
        end
        PULSE: begin
          if (timer_zero) begin
            s_n_q   <= 1'b1;
            r_n_q   <= 1'b1;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_zero) begin
            done_q    <= 1'b1;
            q_state_q <= target_q;
            state_q   <= CHECK;
          end
        end
        CHECK: begin
          if (readback_bad) begin
            err_q[ERR_READBACK] <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = idle;
  assign S_n       = s_n_q;
  assign R_n       = r_n_q;
  assign done      = done_q;
  assign err       = err_q;
  assign q_state   = q_state_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural NAND SR latch on S_n/R_n.
module tb_sr_latch_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_req = 1'b0;
  logic       clr_req = 1'b0;
  logic       req_ready;
  logic       S_n;
  logic       R_n;
  logic       Q_fb;
  logic       Q_not_fb;
  logic       done;
  logic [1:0] err;
  logic       q_state;

  logic lq = 1'b0;
  logic stuck_lo = 1'b0;
  int   both_lo = 0;
  int   n_checks = 0;
  int   n_passed = 0;

  always #5 clk = ~clk;

  sr_latch_driver dut (
    .clk       (clk),
    .rst       (rst),
    .set_req   (set_req),
    .clr_req   (clr_req),
    .req_ready (req_ready),
    .S_n       (S_n),
    .R_n       (R_n),
    .Q_fb      (Q_fb),
    .Q_not_fb  (Q_not_fb),
    .done      (done),
    .err       (err),
    .q_state   (q_state)
  );

  always @(posedge clk) begin
    if (!S_n && R_n) lq <= 1'b1;
    else if (S_n && !R_n) lq <= 1'b0;
  end
  assign Q_fb     = stuck_lo ? 1'b0 : lq;
  assign Q_not_fb = ~lq;

  always @(negedge clk) begin
    if (!S_n && !R_n) both_lo++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_passed++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  // Called just after a rising edge with the DUT idle; drives one request cycle, observes 8 more.
  task automatic run_op(input logic s, input logic c, output int rdy0, output int rdy1,
                        output int s_lo, output int r_lo, output int done_at);
    rdy0 = 0; rdy1 = 0; s_lo = 0; r_lo = 0; done_at = 0;
    set_req = s;
    clr_req = c;
    @(negedge clk);
    rdy0 = int'(req_ready);
    @(posedge clk);
    #1;
    set_req = 1'b0;
    clr_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) rdy1 = int'(req_ready);
      if (!S_n) s_lo++;
      if (!R_n) r_lo++;
      if (done) done_at = (done_at == 0) ? k : 99;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic       s;
    logic       c;
    int         exp_s_lo;
    int         exp_r_lo;
    int         exp_done_at;
    int         exp_rdy1;
    logic       exp_q;
    logic [1:0] exp_err;
    logic       exp_lq;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int rdy0, rdy1, s_lo, r_lo, done_at, n_acc, n_done;
    int acc_at [4];

    vecs[0] = '{1'b1, 1'b0, 2, 0, 4, 0, 1'b1, 2'b00, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 2, 0, 4, 0, 1'b1, 2'b00, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 0, 2, 4, 0, 1'b0, 2'b00, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 0, 2, 4, 0, 1'b0, 2'b00, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 2, 0, 4, 0, 1'b1, 2'b00, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 0, 0, 0, 1, 1'b1, 2'b01, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 0, 2, 4, 0, 1'b0, 2'b01, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_S_n", int'(S_n), 1);
    chk("rst_R_n", int'(R_n), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_q_state", int'(q_state), 0);
    chk("rst_req_ready", int'(req_ready), 1);

    // Reset lands in the second PULSE cycle of a set operation.
    @(posedge clk);
    #1 set_req = 1'b1;
    @(posedge clk);
    #1 set_req = 1'b0;
    @(negedge clk);
    chk("abort_pulse_c1_S_n", int'(S_n), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_pulse_c2_S_n", int'(S_n), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_S_n_released", int'(S_n), 1);
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    chk("abort_q_state", int'(q_state), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_req_ready", int'(req_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].s, vecs[i].c, rdy0, rdy1, s_lo, r_lo, done_at);
      chk($sformatf("v%0d_rdy0", i), rdy0, 1);
      chk($sformatf("v%0d_rdy1", i), rdy1, vecs[i].exp_rdy1);
      chk($sformatf("v%0d_S_n_low", i), s_lo, vecs[i].exp_s_lo);
      chk($sformatf("v%0d_R_n_low", i), r_lo, vecs[i].exp_r_lo);
      chk($sformatf("v%0d_done_at", i), done_at, vecs[i].exp_done_at);
      chk($sformatf("v%0d_q_state", i), int'(q_state), int'(vecs[i].exp_q));
      chk($sformatf("v%0d_err", i), int'(err), int'(vecs[i].exp_err));
      chk($sformatf("v%0d_Q_fb", i), int'(Q_fb), int'(vecs[i].exp_lq));
    end

    // set_req held high: one operation per accept, accepts spaced by a full operation.
    n_acc = 0;
    n_done = 0;
    set_req = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (req_ready && set_req) begin
        if (n_acc < 4) acc_at[n_acc] = k;
        n_acc++;
      end
      if (done) n_done++;
      @(posedge clk);
      #1;
    end
    set_req = 1'b0;
    chk("held_accepts", n_acc, 3);
    chk("held_dones", n_done, 3);
    if (n_acc >= 3) begin
      chk("held_spacing_1", acc_at[1] - acc_at[0], 5);
      chk("held_spacing_2", acc_at[2] - acc_at[1], 5);
    end else begin
      chk("held_spacing_seen", n_acc, 3);
    end
    chk("held_q_state", int'(q_state), 1);
    repeat (2) @(posedge clk);
    #1;

    // Readback with Q_fb stuck low, starting from a clean reset.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    stuck_lo = 1'b1;
    run_op(1'b1, 1'b0, rdy0, rdy1, s_lo, r_lo, done_at);
    chk("stuck_done_at", done_at, 4);
    chk("stuck_q_state", int'(q_state), 1);
`ifdef SR_READBACK_EN
    chk("stuck_err", int'(err), 2);
`else
    chk("stuck_err", int'(err), 0);
`endif
    stuck_lo = 1'b0;

    chk("never_both_low", both_lo, 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 2: clocks an active-low S_n or R_n pulse is held low; legal range 1..15.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1: clocks with S_n=R_n=1 after each pulse, before the result is sampled; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port set_req, input, 1: request to set the latch; consumed only when req_ready=1.
REQ-006 SHALL have port clr_req, input, 1: request to reset the latch; consumed only when req_ready=1.
REQ-007 SHALL have port req_ready, output, 1: driver is idle and accepts a request this cycle.
REQ-008 SHALL have port S_n, output, 1: active-low set drive to the NAND SR latch.
REQ-009 SHALL have port R_n, output, 1: active-low reset drive to the NAND SR latch.
REQ-010 SHALL have port Q_fb, input, 1: latch Q readback.
REQ-011 SHALL have port Q_not_fb, input, 1: latch Q_not readback.
REQ-012 SHALL have port done, output, 1: one-cycle pulse marking operation completion.
REQ-013 SHALL have port err, output, 2: sticky error flags; bit0 = conflict, bit1 = readback mismatch.
REQ-014 SHALL have port q_state, output, 1: last value commanded to the latch.

Function
REQ-015 SHALL implement the FSM IDLE -> PULSE -> SETTLE -> CHECK -> IDLE.
REQ-016 SHALL assert req_ready only in IDLE.
REQ-017 In IDLE with set_req=1 and clr_req=0, SHALL latch target=1 and enter PULSE next edge.
REQ-018 In IDLE with clr_req=1 and set_req=0, SHALL latch target=0 and enter PULSE next edge.
REQ-019 In IDLE with set_req=1 and clr_req=1, SHALL set err[0], stay in IDLE, drive no pulse and emit no done.
REQ-020 In PULSE, SHALL drive S_n=0 (target=1) or R_n=0 (target=0) for exactly PULSE_CYCLES clocks, then enter SETTLE.
REQ-021 SHALL never drive S_n=0 and R_n=0 in the same cycle, in any state.
REQ-022 In SETTLE, SHALL hold S_n=R_n=1 for exactly SETTLE_CYCLES clocks, then enter CHECK.
REQ-023 In CHECK (one cycle), SHALL update q_state to target, pulse done=1 and return to IDLE.
REQ-024 Request-accept to done SHALL take exactly PULSE_CYCLES+SETTLE_CYCLES+1 clocks; the next request is accepted in the cycle after done.
REQ-025 SHALL ignore requests while req_ready=0; requests are not queued.
REQ-026 SHALL keep err bits set until rst.
REQ-027 SHALL drive S_n=R_n=1 in IDLE, SETTLE and CHECK.

Reset
REQ-028 On rst=1 at a clock edge, SHALL set: state IDLE, S_n=1, R_n=1, done=0, err=0, q_state=0, timer=0, req_ready=1 on the following cycle.
REQ-029 rst asserted mid-PULSE SHALL release S_n/R_n to 1 on that edge; the aborted operation SHALL produce no done and no q_state update.

Configuration
REQ-030 With SR_READBACK_EN defined, CHECK SHALL set err[1] if Q_fb!=target or Q_not_fb!=~target; done and the q_state update still occur.
REQ-031 Without SR_READBACK_EN, Q_fb/Q_not_fb SHALL be ignored and err[1] tied to 0.

Structure
REQ-032 Package sr_drv_pkg SHALL hold the FSM state typedef (IDLE, PULSE, SETTLE, CHECK) and the err bit-index constants ERR_CONFLICT=0 and ERR_READBACK=1.
REQ-033 SHALL instantiate one sub-module, sr_pulse_timer: a 4-bit down-counter with load and zero flag, shared by PULSE and SETTLE.

Verification
REQ-034 Scenario: after reset, set_req=1 for 1 cycle -> S_n=0 for 2 cycles, R_n=1 throughout, done at accept+4, q_state=1, err=0.
REQ-035 Scenario: clr_req=1 with latch model Q=1 -> R_n=0 for 2 cycles, done at accept+4, q_state=0, Q_fb=0.
REQ-036 Scenario: set_req=clr_req=1 in IDLE -> err=2'b01, S_n=R_n=1, no done, req_ready stays 1.
REQ-037 Scenario: SR_READBACK_EN defined, Q_fb stuck at 0, set_req -> done pulses, err=2'b10, q_state=1.
REQ-038 Scenario: rst in 2nd PULSE cycle -> S_n=1 on that edge, no done, q_state=0, err=0, next set_req completes normally.
REQ-039 Scenario: set_req held high across a full operation -> exactly one operation per accept, back-to-back accepts spaced 5 cycles with default parameters; S_n and R_n never both 0 (assertion).
